// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature display back-end:
// controller states, segment patterns and the decimal overflow threshold.
package temp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALE  = 2'd1,
    CONV   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Segments are active-low, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one binary bit shifted in per cycle, VAL_W cycles
// after start. done is high during the cycle whose edge shifts in the last bit.
module bin2bcd_seq #(
  parameter int VAL_W  = 12,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]    sr_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                           : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg  <= '0;
      bcd_reg <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      sr_reg  <= bin;
      bcd_reg <= '0;
      cnt_reg <= CNT_W'(VAL_W);
    end else if (cnt_reg != '0) begin
      // Corrected nibbles and the binary register shift left as one word.
      {bcd_reg, sr_reg} <= {adj[4*DIGITS-2:0], sr_reg, 1'b0};
      cnt_reg           <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == CNT_W'(1));
  assign bcd  = bcd_reg;

endmodule

// File: rtl/temp_display_driver.sv
// Raw sensor code -> scaled decimal temperature on a time-multiplexed
// DIGITS-wide 7-segment display with blanking, overflow dashes and scanning.
module temp_display_driver
  import temp_disp_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          DIGITS      = 3,
  parameter int unsigned SCALE_NUM   = 785156,
  parameter int          SCALE_SHIFT = 20,
  parameter int unsigned OFFSET      = 100,
  parameter int          VAL_W       = 12,
  parameter int          SCAN_DIV    = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] dig_en
);

  localparam int PROD_W = DATA_W + 32;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [SUM_W-1:0] OVF_LIM = SUM_W'(pow10(DIGITS));
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   data_reg;
  logic                ovf_pend_reg;
  logic                overflow_reg;
  logic [PROD_W-1:0]   prod;
  logic [SUM_W-1:0]    full_val;
  logic                fits;
  logic                bcd_start, bcd_done;
  logic [4*DIGITS-1:0] bcd;
  logic [6:0]          pat_next [DIGITS];
  logic [6:0]          disp_reg [DIGITS];
  logic                lead_seen;
  logic [SCAN_W-1:0]   scan_cnt_reg;
  logic [DIGITS-1:0]   dig_en_reg, dig_rot;

  // Scaling at full precision; the result is truncated only after range checks.
  assign prod     = PROD_W'(data_reg) * PROD_W'(SCALE_NUM);
  assign full_val = SUM_W'(prod >> SCALE_SHIFT) + SUM_W'(OFFSET);
  assign fits     = ((full_val >> VAL_W) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      ovf_pend_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && data_valid) data_reg <= data_in;
      if (state_reg == SCALE) ovf_pend_reg <= (full_val >= OVF_LIM) || !fits;
      if (state_reg == COMMIT) overflow_reg <= ovf_pend_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    bcd_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (data_valid) state_next = SCALE;
      end
      SCALE: begin
        bcd_start  = 1'b1;
        state_next = CONV;
      end
      CONV:    if (bcd_done) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .bin   (full_val[VAL_W-1:0]),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Walk from the most significant digit down; a digit shows once any
  // higher-or-equal digit is non-zero, and digit 0 always shows.
  always_comb begin
    lead_seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_seen = lead_seen | (bcd[i*4 +: 4] != 4'd0) | (i == 0);
      if (ovf_pend_reg)   pat_next[i] = SEG_DASH;
      else if (lead_seen) pat_next[i] = seg_decode(bcd[i*4 +: 4]);
      else                pat_next[i] = SEG_BLANK;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_disp
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  disp_reg[gi] <= SEG_BLANK;
        else if (state_reg == COMMIT) disp_reg[gi] <= pat_next[gi];
      end
      assign dig_rot[gi] = dig_en_reg[(gi + DIGITS - 1) % DIGITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      dig_en_reg   <= DIGITS'(1);
    end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      dig_en_reg   <= dig_rot;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    seg_out = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_en_reg[i]) seg_out = disp_reg[i];
    end
  end

  assign overflow = overflow_reg;
  assign dig_en   = dig_en_reg;

endmodule

// File: tb/tb_temp_display_driver.sv
// Scoreboard bench: two driver instances (3 digits/offset 100, 2 digits/offset 0)
// share one stimulus stream; a negedge monitor checks every displayed digit.
module tb_temp_display_driver;

  localparam int VAL_W    = 12;
  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct packed {
    logic            ovf;
    logic [5:0][6:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       busy_a, ovf_a, busy_b, ovf_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] en_a;
  logic [1:0] en_b;

  exp_t q_a[$], q_b[$];
  exp_t cur_a, cur_b;
  logic busy_a_d = 1'b0, busy_b_d = 1'b0;
  int   n_cmp = 0, n_bad = 0, k = 0;

  temp_display_driver #(.SCAN_DIV(SCAN_DIV)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .busy(busy_a), .overflow(ovf_a), .seg_out(seg_a), .dig_en(en_a));

  temp_display_driver #(.DIGITS(2), .OFFSET(0), .SCAN_DIV(SCAN_DIV)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .busy(busy_b), .overflow(ovf_b), .seg_out(seg_b), .dig_en(en_b));

  always #5 clk = ~clk;

  // Reference: temperature as an integer, then decimal digits by division.
  function automatic exp_t model(int data, int digits, int offset);
    exp_t   r;
    longint v, t, lim;
    v = (longint'(data) * 785156) / 1048576 + longint'(offset);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r.ovf = (v >= lim) || (v >= 4096);
    t = v;
    for (int i = 0; i < 6; i++) begin
      r.seg[i] = 7'b1111111;
      if (i < digits) begin
        if (r.ovf)                r.seg[i] = 7'b0111111;
        else if (i == 0 || t != 0) r.seg[i] = SEG_TAB[int'(t % 10)];
        t = t / 10;
      end
    end
    return r;
  endfunction

  function automatic exp_t blank_disp();
    exp_t r;
    r.ovf = 1'b0;
    for (int i = 0; i < 6; i++) r.seg[i] = 7'b1111111;
    return r;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Monitor: a busy falling edge means a commit; pop its expected display.
  always @(negedge clk) begin
    int ia, ib;
    if (!rst_n) begin
      cur_a = blank_disp();
      cur_b = blank_disp();
      busy_a_d = 1'b0;
      busy_b_d = 1'b0;
    end else begin
      if (busy_a_d && !busy_a) begin
        if (q_a.size() == 0) chk("pop_a_nonempty", 64'(q_a.size()), 64'(1));
        else cur_a = q_a.pop_front();
      end
      if (busy_b_d && !busy_b) begin
        if (q_b.size() == 0) chk("pop_b_nonempty", 64'(q_b.size()), 64'(1));
        else cur_b = q_b.pop_front();
      end
      busy_a_d = busy_a;
      busy_b_d = busy_b;
    end
    ia = (k / SCAN_DIV) % 3;
    ib = (k / SCAN_DIV) % 2;
    chk("dig_en_a", 64'(en_a), 64'(1) << ia);
    chk("seg_a", 64'(seg_a), 64'(cur_a.seg[ia]));
    chk("ovf_a", 64'(ovf_a), 64'(cur_a.ovf));
    chk("dig_en_b", 64'(en_b), 64'(1) << ib);
    chk("seg_b", 64'(seg_b), 64'(cur_b.seg[ib]));
    chk("ovf_b", 64'(ovf_b), 64'(cur_b.ovf));
  end

  task automatic send(input logic [7:0] d, input bit drop);
    int cyc;
    data_in    = d;
    data_valid = 1'b1;
    q_a.push_back(model(int'(d), 3, 100));
    q_b.push_back(model(int'(d), 2, 0));
    @(negedge clk);
    cyc = 0;
    data_valid = 1'b0;
    while (busy_a && cyc < 100) begin
      if (drop && cyc == 3) begin
        data_in    = ~d;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("busy_cycles", 64'(cyc), 64'(VAL_W + 2));
    chk("busy_b_done", 64'(busy_b), 64'(0));
    $display("txn data=%0d drop_strobe=%0d busy_cycles=%0d", d, drop, cyc);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy_a", 64'(busy_a), 64'(0));
    chk("rst_ovf_a", 64'(ovf_a), 64'(0));
    chk("rst_seg_a", 64'(seg_a), 64'h7f);
    chk("rst_en_a", 64'(en_a), 64'(1));
    chk("rst_busy_b", 64'(busy_b), 64'(0));
    chk("rst_seg_b", 64'(seg_b), 64'h7f);
    chk("rst_en_b", 64'(en_b), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    send(8'd0, 1'b0);
    send(8'd255, 1'b1);
    send(8'd100, 1'b0);
    send(8'd10, 1'b0);
    send(8'd134, 1'b0);
    send(8'd133, 1'b0);
    repeat (20) send(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));

    // Abort a conversion with an asynchronous reset; no commit is expected.
    data_in    = 8'd200;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'd255, 1'b0);
    send(8'd50, 1'b0);
    repeat (20) @(negedge clk);

    chk("q_a_drained", 64'(q_a.size()), 64'(0));
    chk("q_b_drained", 64'(q_b.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
